scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux_pkg.sv | 15 +
 rtl/tick_gen.sv | 31 +++
 rtl/scan_mux.sv | 92 +++++++++
 tb/tb_scan_mux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan multiplexer: FSM state encoding and
// the width of the channel index.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  function automatic int sw_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 while enabled and pulses tick for
// the cycle in which the count sits at its terminal value.
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // clr wins over en so a fresh scan always starts a full period from zero
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = en & ~clr & (count == LAST);

endmodule

// File: rtl/scan_mux.sv
// Channel multiplexer with manual selection, timed auto-scan and a freeze
// input; every output is registered.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int SCAN_DIV = 50_000_000,
  localparam int SW_W     = sw_w(CHANNELS)
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SW_W-1:0]           sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          dout,
  output logic [SW_W-1:0]           chan,
  output logic                      step
);

  localparam logic [SW_W-1:0] LAST_CH = SW_W'(CHANNELS - 1);

  state_t            st, ns;
  logic              tick, pre_en, pre_clr;
  logic [SW_W-1:0]   sel_clamped, chan_adv;
  logic [WIDTH-1:0]  slice;

  always_ff @(posedge CLOCK_50) begin
    if (reset) st <= ST_MANUAL;
    else       st <= ns;
  end

  // Actions on an edge follow the state being entered, so hold takes effect
  // on the very edge it is first seen and entry to SCAN restarts the prescaler.
  always_comb begin
    ns      = ST_MANUAL;
    pre_en  = 1'b0;
    pre_clr = 1'b0;
    if (hold)      ns = ST_FROZEN;
    else if (mode) ns = ST_SCAN;
    if (ns == ST_SCAN) begin
      pre_en  = (st == ST_SCAN);
      pre_clr = (st != ST_SCAN);
    end
  end

  always_comb begin
    sel_clamped = (int'(sel) >= CHANNELS) ? LAST_CH : sel;
    chan_adv    = (chan == LAST_CH) ? '0 : chan + SW_W'(1);
    slice       = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (chan == SW_W'(k)) slice = data_in[k*WIDTH +: WIDTH];
    end
  end

  tick_gen #(
    .DIV(SCAN_DIV)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .en      (pre_en),
    .clr     (pre_clr),
    .tick    (tick)
  );

  // dout samples the channel held before this edge, giving one cycle of lag
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      chan <= '0;
      dout <= '0;
      step <= 1'b0;
    end else begin
      unique case (ns)
        ST_SCAN: begin
          dout <= slice;
          step <= tick;
          if (tick) chan <= chan_adv;
        end
        ST_MANUAL: begin
          dout <= slice;
          step <= 1'b0;
          chan <= sel_clamped;
        end
        default: begin
          step <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: scripted scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_scan_mux;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 3;
  localparam int SCAN_DIV = 4;
  localparam int SW_W     = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      mode = 1'b0;
  logic                      hold = 1'b0;
  logic [SW_W-1:0]           sel = '0;
  logic [CHANNELS*WIDTH-1:0] data_in = 12'hCBA;
  logic [WIDTH-1:0]          dout;
  logic [SW_W-1:0]           chan;
  logic                      step;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;
  int cycle = 0;

  int         m_chan = 0;
  int         m_phase = 0;
  logic [3:0] m_dout = 4'h0;
  bit         m_step = 1'b0;
  bit         m_in_scan = 1'b0;

  scan_mux #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .data_in (data_in),
    .sel     (sel),
    .mode    (mode),
    .hold    (hold),
    .dout    (dout),
    .chan    (chan),
    .step    (step)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] chan_val(input logic [11:0] d, input int c);
    return d[c*4 +: 4];
  endfunction

  // Reference behaviour: what every output must become on each rising edge
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      if (reset) begin
        m_chan = 0; m_dout = 4'h0; m_step = 1'b0; m_phase = 0; m_in_scan = 1'b0;
        checking = 1'b1;
      end else if (hold) begin
        m_step = 1'b0;
        m_in_scan = 1'b0;
      end else if (mode) begin
        m_dout = chan_val(data_in, m_chan);
        m_step = 1'b0;
        if (!m_in_scan) begin
          m_phase = 0;
        end else if (m_phase == SCAN_DIV - 1) begin
          m_phase = 0;
          m_chan = (m_chan + 1) % CHANNELS;
          m_step = 1'b1;
        end else begin
          m_phase++;
        end
        m_in_scan = 1'b1;
      end else begin
        m_dout = chan_val(data_in, m_chan);
        m_chan = (int'(sel) >= CHANNELS) ? CHANNELS - 1 : int'(sel);
        m_step = 1'b0;
        m_in_scan = 1'b0;
      end
    end
  end

  // Continuous comparison against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        checks++;
        if (chan !== SW_W'(m_chan)) begin
          errors++;
          $display("[TB] FAIL model_chan cycle %0d: actual=%0d required=%0d", cycle, chan, m_chan);
        end
        checks++;
        if (dout !== m_dout) begin
          errors++;
          $display("[TB] FAIL model_dout cycle %0d: actual=%0h required=%0h", cycle, dout, m_dout);
        end
        checks++;
        if (step !== m_step) begin
          errors++;
          $display("[TB] FAIL model_step cycle %0d: actual=%0b required=%0b", cycle, step, m_step);
        end
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit m, input bit h,
                               input logic [SW_W-1:0] s, input int n);
    reset = r;
    mode  = m;
    hold  = h;
    sel   = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [SW_W-1:0] exp_chan,
                             input logic [3:0] exp_dout, input logic exp_step);
    checks++;
    if (chan !== exp_chan || dout !== exp_dout || step !== exp_step) begin
      errors++;
      $display("[TB] FAIL %s: actual chan=%0d dout=%0h step=%0b required chan=%0d dout=%0h step=%0b",
               name, chan, dout, step, exp_chan, exp_dout, exp_step);
    end
  endtask

  initial begin
    $display("[TB] scan_mux bench start");

    applyStimulus(1, 0, 0, 2'd0, 2);
    checkOutput("reset", 2'd0, 4'h0, 1'b0);

    applyStimulus(0, 0, 0, 2'd2, 1);
    checkOutput("manual_chan", 2'd2, 4'hA, 1'b0);
    applyStimulus(0, 0, 0, 2'd2, 1);
    checkOutput("manual_dout", 2'd2, 4'hC, 1'b0);

    applyStimulus(0, 0, 0, 2'd0, 1);
    checkOutput("manual_back", 2'd0, 4'hC, 1'b0);
    applyStimulus(0, 0, 0, 2'd3, 1);
    checkOutput("clamp_chan", 2'd2, 4'hA, 1'b0);
    applyStimulus(0, 0, 0, 2'd3, 1);
    checkOutput("clamp_dout", 2'd2, 4'hC, 1'b0);

    applyStimulus(0, 0, 0, 2'd0, 2);
    checkOutput("pre_scan", 2'd0, 4'hA, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("scan_entry", 2'd0, 4'hA, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 3);
    checkOutput("scan_wait0", 2'd0, 4'hA, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("scan_adv1", 2'd1, 4'hA, 1'b1);
    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("scan_dout_b", 2'd1, 4'hB, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 2);
    checkOutput("scan_wait1", 2'd1, 4'hB, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("scan_adv2", 2'd2, 4'hB, 1'b1);
    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("scan_dout_c", 2'd2, 4'hC, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 3);
    checkOutput("scan_wrap", 2'd0, 4'hC, 1'b1);
    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("scan_dout_a", 2'd0, 4'hA, 1'b0);

    applyStimulus(0, 1, 0, 2'd0, 1);
    applyStimulus(0, 1, 1, 2'd0, 10);
    checkOutput("freeze_hold", 2'd0, 4'hA, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 3);
    checkOutput("freeze_restart", 2'd0, 4'hA, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("freeze_no_adv", 2'd0, 4'hA, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("freeze_adv", 2'd1, 4'hA, 1'b1);

    applyStimulus(0, 1, 1, 2'd0, 3);
    checkOutput("prio_hold_mode", 2'd1, 4'hA, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 4);
    checkOutput("prio_terminal", 2'd1, 4'hB, 1'b0);
    applyStimulus(1, 1, 0, 2'd0, 1);
    checkOutput("prio_reset", 2'd0, 4'h0, 1'b0);

    applyStimulus(0, 1, 0, 2'd0, 1);
    checkOutput("post_reset_scan", 2'd0, 4'hA, 1'b0);
    applyStimulus(0, 1, 0, 2'd0, 4);
    checkOutput("exit_at_1", 2'd1, 4'hA, 1'b1);
    applyStimulus(0, 0, 0, 2'd0, 1);
    checkOutput("mode_exit", 2'd0, 4'hB, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) hold = ~hold;
      sel = SW_W'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) data_in = 12'($urandom);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
